// File: rtl/wb_line_slave.sv
// wb_line_slave: Wishbone classic slave that moves 64-byte lines to and from a
// 128-bit command/response memory port as four beats per line.
// Optional build macro WB_LINE_SLAVE_SKIP_CLEAN_EN: a write whose byte mask is
// all zero is acknowledged without issuing any memory commands.
module wb_line_slave (
  input  logic         clk,
  input  logic         rst,
  input  logic         ws_cyc,
  input  logic         ws_stb,
  input  logic         ws_we,
  input  logic [31:0]  ws_addr,
  input  logic [511:0] ws_dout,
  input  logic [63:0]  ws_dm,
  output logic [511:0] ws_din,
  output logic         ws_ack,
  output logic         mem_cmd_valid,
  output logic         mem_cmd_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  output logic [15:0]  mem_wmask_n,
  input  logic         mem_cmd_ready,
  input  logic [127:0] mem_rdata,
  input  logic         mem_rvalid
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_CMD  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] WR_CMD  = 3'd3;
  localparam logic [2:0] ACK     = 3'd4;
  localparam logic [2:0] DRAIN   = 3'd5;

  logic [2:0]   state;
  logic [2:0]   state_nxt;
  logic [25:0]  line_q;
  logic [511:0] wdata_q;
  logic [63:0]  wmask_q;
  logic [1:0]   beat;
  logic [1:0]   ret_cnt;
  logic [2:0]   outst;
  logic [2:0]   outst_nxt;
  logic         req;
  logic         in_cmd;
  logic         cmd_xfer;
  logic         rd_xfer;
  logic         beat_ok;
  logic         store;
  logic         skip_clean;
  logic         unused_addr_bits;

  assign unused_addr_bits = ^ws_addr[5:0];

  // A request is only taken while the previous acknowledge is not showing.
  assign req      = ws_cyc & ws_stb & ~ws_ack;
  assign in_cmd   = (state == WR_CMD) | (state == RD_CMD);
  // Dropping ws_cyc withdraws the command so an aborted beat never transfers.
  assign mem_cmd_valid = in_cmd & ws_cyc;
  assign mem_cmd_we    = (state == WR_CMD);
  assign mem_addr      = in_cmd ? {line_q, beat, 4'h0} : 32'h0;
  assign mem_wdata     = (state == WR_CMD) ? wdata_q[{beat, 7'd0} +: 128] : 128'h0;
  assign mem_wmask_n   = (state == WR_CMD) ? ~wmask_q[{beat, 4'd0} +: 16] : 16'h0;

  assign cmd_xfer = mem_cmd_valid & mem_cmd_ready;
  assign rd_xfer  = cmd_xfer & (state == RD_CMD);
  // Returns with nothing outstanding are strays (e.g. after a reset) and are dropped.
  assign beat_ok  = mem_rvalid & (outst != 3'd0);
  assign store    = beat_ok & ((state == RD_CMD) | (state == RD_WAIT));

`ifdef WB_LINE_SLAVE_SKIP_CLEAN_EN
  assign skip_clean = ws_we & (ws_dm == 64'h0);
`else
  assign skip_clean = 1'b0;
`endif

  // Outstanding reads: issue and return in the same cycle cancel out.
  always_comb begin
    outst_nxt = outst;
    if (rd_xfer && !beat_ok)      outst_nxt = outst + 3'd1;
    else if (!rd_xfer && beat_ok) outst_nxt = outst - 3'd1;
  end

  // Next-state logic for the line transfer sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (ws_we) state_nxt = skip_clean ? ACK : WR_CMD;
          else       state_nxt = RD_CMD;
        end
      end
      WR_CMD: begin
        if (!ws_cyc)                         state_nxt = IDLE;
        else if (cmd_xfer && beat == 2'd3)   state_nxt = ACK;
      end
      RD_CMD: begin
        if (!ws_cyc)                         state_nxt = DRAIN;
        else if (cmd_xfer && beat == 2'd3)   state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (!ws_cyc)                         state_nxt = DRAIN;
        else if (store && ret_cnt == 2'd3)   state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      DRAIN: begin
        if (outst_nxt == 3'd0)               state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: state, acknowledge pulse, beat and outstanding counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ws_ack <= 1'b0;
      beat   <= 2'd0;
      outst  <= 3'd0;
    end else begin
      state  <= state_nxt;
      ws_ack <= (state == ACK);
      outst  <= outst_nxt;
      if (state == IDLE && req) beat <= 2'd0;
      else if (cmd_xfer)        beat <= beat + 2'd1;
    end
  end

  // Request capture and read-line assembly; ws_din holds until the next stored beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q  <= 26'h0;
      wdata_q <= 512'h0;
      wmask_q <= 64'h0;
      ret_cnt <= 2'd0;
      ws_din  <= 512'h0;
    end else begin
      if (state == IDLE && req) begin
        line_q  <= ws_addr[31:6];
        wdata_q <= ws_dout;
        wmask_q <= ws_dm;
        ret_cnt <= 2'd0;
      end
      if (store) begin
        ws_din[{ret_cnt, 7'd0} +: 128] <= mem_rdata;
        ret_cnt <= ret_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_line_slave.sv
// tb_wb_line_slave: directed and randomized line transfers against a
// behavioural memory model (byte-masked line writes, in-order read returns).
module tb_wb_line_slave;

  logic         clk;
  logic         rst;
  logic         ws_cyc;
  logic         ws_stb;
  logic         ws_we;
  logic [31:0]  ws_addr;
  logic [511:0] ws_dout;
  logic [63:0]  ws_dm;
  logic [511:0] ws_din;
  logic         ws_ack;
  logic         mem_cmd_valid;
  logic         mem_cmd_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [15:0]  mem_wmask_n;
  logic         mem_cmd_ready;
  logic [127:0] mem_rdata;
  logic         mem_rvalid;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [15:0]  mask_n;
  } cmd_t;

  typedef struct {
    int           due;
    logic [127:0] data;
  } rsp_t;

  cmd_t         act_q[$];
  rsp_t         rsp_q[$];
  logic [127:0] mem_model [logic [31:0]];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc_cnt = 0;
  int           ack_cnt = 0;
  int           ready_mode = 0;
  int           rd_lat = 1;
  logic         held = 1'b0;
  logic [176:0] held_fields;
  logic [176:0] cur_fields;

  wb_line_slave dut (
    .clk           (clk),
    .rst           (rst),
    .ws_cyc        (ws_cyc),
    .ws_stb        (ws_stb),
    .ws_we         (ws_we),
    .ws_addr       (ws_addr),
    .ws_dout       (ws_dout),
    .ws_dm         (ws_dm),
    .ws_din        (ws_din),
    .ws_ack        (ws_ack),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_we    (mem_cmd_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask_n   (mem_wmask_n),
    .mem_cmd_ready (mem_cmd_ready),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: written beats from the model, otherwise an address-derived pattern.
  function automatic logic [127:0] readBeat(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd1};
  endfunction

  function automatic logic [511:0] readLine(input logic [31:0] addr);
    logic [511:0] l;
    logic [1:0]   kk;
    l = '0;
    for (int k = 0; k < 4; k++) begin
      kk = 2'(k);
      l[128*k +: 128] = readBeat({addr[31:6], kk, 4'h0});
    end
    return l;
  endfunction

  function automatic void writeLine(input logic [31:0] addr, input logic [511:0] data,
                                    input logic [63:0] dm);
    logic [127:0] b;
    logic [1:0]   kk;
    for (int k = 0; k < 4; k++) begin
      kk = 2'(k);
      b = readBeat({addr[31:6], kk, 4'h0});
      for (int j = 0; j < 16; j++)
        if (dm[16*k + j]) b[8*j +: 8] = data[128*k + 8*j +: 8];
      mem_model[{addr[31:6], kk, 4'h0}] = b;
    end
  endfunction

  function automatic logic [511:0] randLine();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory side: drives ready/read returns after each edge, records transfers at mid-cycle.
  initial begin
    mem_cmd_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    forever begin
      @(posedge clk);
      cyc_cnt++;
      #1;
      case (ready_mode)
        0:       mem_cmd_ready = 1'b1;
        1:       mem_cmd_ready = ~mem_cmd_ready;
        default: mem_cmd_ready = 1'($urandom_range(0, 1));
      endcase
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc_cnt) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rsp_q[0].data;
        void'(rsp_q.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
      @(negedge clk);
      cur_fields = {mem_cmd_we, mem_addr, mem_wdata, mem_wmask_n};
      if (mem_cmd_valid === 1'b1 && held)
        checkOutput("cmd_stable", 512'(cur_fields), 512'(held_fields));
      held        = (mem_cmd_valid === 1'b1) && (mem_cmd_ready === 1'b0);
      held_fields = cur_fields;
      if (mem_cmd_valid === 1'b1 && mem_cmd_ready === 1'b1) begin
        act_q.push_back('{we: mem_cmd_we, addr: mem_addr, wdata: mem_wdata, mask_n: mem_wmask_n});
        if (!mem_cmd_we)
          rsp_q.push_back('{due: cyc_cnt + rd_lat, data: readBeat(mem_addr)});
      end
      if (ws_ack === 1'b1) ack_cnt++;
    end
  end

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [511:0] data,
                               input logic [63:0] dm, output int req_c);
    ws_cyc  = 1'b1;
    ws_stb  = 1'b1;
    ws_we   = we;
    ws_addr = addr;
    ws_dout = data;
    ws_dm   = dm;
    req_c   = cyc_cnt;
  endtask

  task automatic waitAck(output int ack_c, output logic [511:0] din_ack);
    logic got;
    got     = 1'b0;
    ack_c   = -1;
    din_ack = '0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (ws_ack === 1'b1) begin
        got     = 1'b1;
        ack_c   = cyc_cnt;
        din_ack = ws_din;
      end
    end
    checkOutput("ack_seen", 512'(got), 512'(1'b1));
    tick();
    ws_cyc = 1'b0;
    ws_stb = 1'b0;
  endtask

  task automatic checkCmds(input logic we, input logic [31:0] addr, input logic [511:0] data,
                           input logic [63:0] dm, input int n);
    logic [1:0]  kk;
    logic [15:0] em;
    checkOutput("cmd_count", 512'(act_q.size()), 512'(n));
    for (int k = 0; k < act_q.size() && k < n; k++) begin
      kk = 2'(k);
      em = ~dm[16*k +: 16];
      checkOutput("cmd_addr", 512'(act_q[k].addr), 512'({addr[31:6], kk, 4'h0}));
      checkOutput("cmd_we", 512'(act_q[k].we), 512'(we));
      if (we) begin
        checkOutput("cmd_wdata", 512'(act_q[k].wdata), 512'(data[128*k +: 128]));
        checkOutput("cmd_mask_n", 512'(act_q[k].mask_n), 512'(em));
      end
    end
    act_q.delete();
  endtask

  task automatic checkIdleZero();
    checkOutput("rst_ws_ack", 512'(ws_ack), 512'(0));
    checkOutput("rst_cmd_valid", 512'(mem_cmd_valid), 512'(0));
    checkOutput("rst_cmd_we", 512'(mem_cmd_we), 512'(0));
    checkOutput("rst_mem_addr", 512'(mem_addr), 512'(0));
    checkOutput("rst_mem_wdata", 512'(mem_wdata), 512'(0));
    checkOutput("rst_wmask_n", 512'(mem_wmask_n), 512'(0));
    checkOutput("rst_ws_din", ws_din, 512'(0));
  endtask

  task automatic doTxn(input logic we, input logic [31:0] addr, input logic [511:0] data,
                       input logic [63:0] dm, input int n_cmds, output int lat);
    int           r;
    int           a;
    int           acks0;
    logic [511:0] exp_line;
    logic [511:0] din_ack;
    acks0    = ack_cnt;
    exp_line = readLine(addr);
    applyStimulus(we, addr, data, dm, r);
    waitAck(a, din_ack);
    lat = a - r;
    if (!we) checkOutput("rd_line_at_ack", din_ack, exp_line);
    repeat (3) tick();
    if (!we) checkOutput("rd_line_hold", ws_din, exp_line);
    checkOutput("single_ack", 512'(ack_cnt - acks0), 512'(1));
    checkCmds(we, addr, data, dm, n_cmds);
    if (we) writeLine(addr, data, dm);
  endtask

  // Directed steps followed by a randomized run.
  initial begin
    int           lat;
    int           r;
    int           acks0;
    logic [511:0] line;
    logic [511:0] exp_line;
    logic [63:0]  dm;
    logic [31:0]  addr;

    rst = 1'b1; ws_cyc = 1'b0; ws_stb = 1'b0; ws_we = 1'b0;
    ws_addr = '0; ws_dout = '0; ws_dm = '0;
    repeat (2) tick();
    checkIdleZero();
    rst = 1'b0;
    tick();

    // Full-mask write with ready always high.
    ready_mode = 0;
    line = {128'hDDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDD3,
            128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCC2,
            128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBB1,
            128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAA0};
    doTxn(1'b1, 32'h0001_2340, line, 64'hFFFF_FFFF_FFFF_FFFF, 4, lat);
    checkOutput("wr_latency", 512'(lat), 512'(6));

    // Read with one-cycle memory latency and known beats.
    rd_lat = 1;
    mem_model[32'h0000_8040] = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
    mem_model[32'h0000_8050] = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
    mem_model[32'h0000_8060] = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
    mem_model[32'h0000_8070] = 128'h4444_4444_4444_4444_4444_4444_4444_4444;
    doTxn(1'b0, 32'h0000_8040, '0, '0, 4, lat);
    checkOutput("rd_known_line", ws_din,
                {128'h4444_4444_4444_4444_4444_4444_4444_4444,
                 128'h3333_3333_3333_3333_3333_3333_3333_3333,
                 128'h2222_2222_2222_2222_2222_2222_2222_2222,
                 128'h1111_1111_1111_1111_1111_1111_1111_1111});

    // Partial mask with ready toggling; stability is checked on every stalled cycle.
    ready_mode = 1;
    doTxn(1'b1, 32'h0000_4C80, randLine(), 64'h0000_0000_0000_FFFF, 4, lat);

    // All-clean write.
    ready_mode = 0;
`ifdef WB_LINE_SLAVE_SKIP_CLEAN_EN
    doTxn(1'b1, 32'h0000_5000, randLine(), 64'h0, 0, lat);
    checkOutput("skip_latency", 512'(lat), 512'(2));
`else
    doTxn(1'b1, 32'h0000_5000, randLine(), 64'h0, 4, lat);
`endif

    // Write abandoned after two command transfers.
    acks0 = ack_cnt;
    applyStimulus(1'b1, 32'h0000_6000, randLine(), 64'hFFFF_FFFF_FFFF_FFFF, r);
    repeat (3) tick();
    ws_cyc = 1'b0; ws_stb = 1'b0;
    repeat (6) tick();
    checkOutput("wr_abort_cmds", 512'(act_q.size()), 512'(2));
    checkOutput("wr_abort_no_ack", 512'(ack_cnt - acks0), 512'(0));
    checkOutput("wr_abort_idle", 512'(mem_cmd_valid), 512'(0));
    act_q.delete();

    // Read abandoned after two commands, then a new read queued behind the drain.
    rd_lat = 5;
    acks0 = ack_cnt;
    applyStimulus(1'b0, 32'h0000_9000, '0, '0, r);
    repeat (3) tick();
    ws_cyc = 1'b0; ws_stb = 1'b0;
    tick();
    checkOutput("rd_abort_cmds", 512'(act_q.size()), 512'(2));
    checkOutput("rd_abort_no_ack", 512'(ack_cnt - acks0), 512'(0));
    act_q.delete();
    doTxn(1'b0, 32'h0000_9440, '0, '0, 4, lat);

    // Reset in the middle of a read with three beats outstanding.
    rd_lat = 6;
    acks0 = ack_cnt;
    applyStimulus(1'b0, 32'h0000_A0C0, '0, '0, r);
    repeat (8) tick();
    rst = 1'b1; ws_cyc = 1'b0; ws_stb = 1'b0;
    tick();
    checkIdleZero();
    rst = 1'b0;
    repeat (6) tick();
    checkOutput("rst_stray_din", ws_din, 512'(0));
    checkOutput("rst_no_ack", 512'(ack_cnt - acks0), 512'(0));
    act_q.delete();

    // Randomized mix over a small pool of lines so reads see earlier writes.
    ready_mode = 2;
    for (int i = 0; i < 12; i++) begin
      rd_lat = $urandom_range(1, 3);
      addr = 32'h00A0_0000 | ($urandom_range(0, 3) << 6) | ($urandom & 32'h3F);
      dm = {$urandom, $urandom};
      if (dm == 64'h0) dm = 64'h1;
      doTxn(1'($urandom_range(0, 1)), addr, randLine(), dm, 4, lat);
    end
    for (int i = 0; i < 4; i++) begin
      rd_lat = $urandom_range(1, 3);
      addr = 32'h00A0_0000 | (32'(i) << 6);
      exp_line = readLine(addr);
      doTxn(1'b0, addr, '0, '0, 4, lat);
      checkOutput("rand_readback", ws_din, exp_line);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
